// File: rtl/datapath_pkg.sv
// Shared constants and the instruction-word layout for the datapath block.
package datapath_pkg;

  localparam int unsigned WORD_W   = 16;
  localparam int unsigned OPC_MSB  = 15;
  localparam int unsigned OPC_LSB  = 12;
  localparam int unsigned MODE_MSB = 11;
  localparam int unsigned MODE_LSB = 10;
  localparam int unsigned LABEL_W  = 10;

  localparam int unsigned OPC_W  = OPC_MSB - OPC_LSB + 1;
  localparam int unsigned MODE_W = MODE_MSB - MODE_LSB + 1;

  // Instruction word: opcode | mode | label, MSB first.
  typedef struct packed {
    logic [OPC_W-1:0]   opc;
    logic [MODE_W-1:0]  mode;
    logic [LABEL_W-1:0] label;
  } ir_t;

endpackage : datapath_pkg

// File: rtl/load_reg.sv
// Parameterized-width register with load enable and async active-low reset.
module load_reg #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] q_d;
  logic [W-1:0] q_q;

  // Next value: load when enabled, otherwise hold.
  always_comb begin
    q_d = q_q;
    if (ld) begin
      q_d = d;
    end
  end

  // State register, cleared immediately on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= W'(0);
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule : load_reg

// File: rtl/datapath.sv
// Instruction register and memory address register pair.
// Build option: define DATAPATH_LABEL_EN to let Tlabel steer the IR label
// field into MAR; otherwise MAR always loads data_bus and Tlabel is ignored.
module datapath
  import datapath_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                ldMAR,
  input  logic [WORD_W-1:0]   data_bus,
  input  logic                ldIR,
  input  logic                Tlabel,
  output logic [OPC_W-1:0]    ir_1,
  output logic [MODE_W-1:0]   ir_2,
  output logic [WORD_W-1:0]   ir_out,
  output logic [WORD_W-1:0]   mar_out
);

  logic [WORD_W-1:0] ir_q;
  logic [WORD_W-1:0] mar_q;
  logic [WORD_W-1:0] mar_src_c;
  ir_t               ir_fields_c;

  assign ir_fields_c = ir_t'(ir_q);

  // MAR source select; the label comes from the pre-edge IR contents.
  always_comb begin
    mar_src_c = data_bus;
`ifdef DATAPATH_LABEL_EN
    if (Tlabel) begin
      mar_src_c = WORD_W'(ir_fields_c.label);
    end
`endif
  end

`ifndef DATAPATH_LABEL_EN
  // Label path compiled out: Tlabel and the label field have no reader.
  logic [LABEL_W:0] unused_label_c;
  assign unused_label_c = {Tlabel, ir_fields_c.label};
`endif

  load_reg #(.W(WORD_W)) u_ir (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ldIR),
    .d     (data_bus),
    .q     (ir_q)
  );

  load_reg #(.W(WORD_W)) u_mar (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ldMAR),
    .d     (mar_src_c),
    .q     (mar_q)
  );

  assign ir_1    = ir_fields_c.opc;
  assign ir_2    = ir_fields_c.mode;
  assign ir_out  = ir_q;
  assign mar_out = mar_q;

endmodule : datapath

// File: tb/tb_datapath.sv
// Self-checking bench for datapath: reference model plus per-cycle compare.
module tb_datapath;

`ifdef DATAPATH_LABEL_EN
  localparam bit LABEL_ON = 1'b1;
`else
  localparam bit LABEL_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ldMAR;
  logic        ldIR;
  logic        Tlabel;
  logic [15:0] data_bus;
  logic [3:0]  ir_1;
  logic [1:0]  ir_2;
  logic [15:0] ir_out;
  logic [15:0] mar_out;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] ir_m  = 16'h0000;
  logic [15:0] mar_m = 16'h0000;
  bit          cmp_en = 1'b0;

  datapath dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ldMAR    (ldMAR),
    .data_bus (data_bus),
    .ldIR     (ldIR),
    .Tlabel   (Tlabel),
    .ir_1     (ir_1),
    .ir_2     (ir_2),
    .ir_out   (ir_out),
    .mar_out  (mar_out)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare of all outputs against the model.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("cyc_ir_out",  ir_out,        ir_m);
      chk("cyc_mar_out", mar_out,       mar_m);
      chk("cyc_ir_1",    16'(ir_1),     16'(ir_m[15:12]));
      chk("cyc_ir_2",    16'(ir_2),     16'(ir_m[11:10]));
    end
  end

  // One clock of stimulus; the model applies the load rules at the edge.
  task automatic drive(input logic li, input logic lm, input logic tl, input logic [15:0] bus);
    logic [15:0] nmar;
    ldIR     = li;
    ldMAR    = lm;
    Tlabel   = tl;
    data_bus = bus;
    @(posedge clk);
    if (rst_n) begin
      nmar = mar_m;
      if (lm) nmar = (LABEL_ON && tl) ? {6'b000000, ir_m[9:0]} : bus;
      if (li) ir_m = bus;
      mar_m = nmar;
    end
    @(negedge clk);
    #1;
  endtask

  // Async reset pulse asserted mid-way through the low clock phase.
  task automatic mid_reset(input bit check_lit);
    #2;
    rst_n    = 1'b0;
    ldIR     = 1'b1;
    ldMAR    = 1'b1;
    data_bus = 16'($urandom);
    #1;
    ir_m  = 16'h0000;
    mar_m = 16'h0000;
    if (check_lit) begin
      chk("midrst_ir_out",  ir_out,    16'h0000);
      chk("midrst_mar_out", mar_out,   16'h0000);
      chk("midrst_ir_1",    16'(ir_1), 16'h0000);
      chk("midrst_ir_2",    16'(ir_2), 16'h0000);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    ldIR     = 1'b1;
    ldMAR    = 1'b1;
    Tlabel   = 1'b1;
    data_bus = 16'hBEEF;
    #2;
    chk("rst_ir_out",  ir_out,    16'h0000);
    chk("rst_mar_out", mar_out,   16'h0000);
    chk("rst_ir_1",    16'(ir_1), 16'h0000);
    chk("rst_ir_2",    16'(ir_2), 16'h0000);
    @(posedge clk);
    #1;
    chk("rst_hold_ir_out",  ir_out,  16'h0000);
    chk("rst_hold_mar_out", mar_out, 16'h0000);
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    #1;

    drive(1'b1, 1'b0, 1'b0, 16'hF155);
    chk("irload_ir_out",  ir_out,    16'hF155);
    chk("irload_ir_1",    16'(ir_1), 16'h000F);
    chk("irload_ir_2",    16'(ir_2), 16'h0000);
    chk("irload_mar_out", mar_out,   16'h0000);

    drive(1'b1, 1'b1, 1'b1, 16'hF755);
    chk("simul_ir_out", ir_out,    16'hF755);
    chk("simul_ir_1",   16'(ir_1), 16'h000F);
    chk("simul_ir_2",   16'(ir_2), 16'h0001);
`ifdef DATAPATH_LABEL_EN
    chk("simul_mar_label", mar_out, 16'h0155);
`else
    chk("simul_mar_bus",   mar_out, 16'hF755);
`endif

    drive(1'b0, 1'b1, 1'b0, 16'h1234);
    chk("busmar_mar_out", mar_out, 16'h1234);
    chk("busmar_ir_keep", ir_out,  16'hF755);

    drive(1'b0, 1'b0, 1'b1, 16'h5A5A);
    chk("tlabel_noload_mar", mar_out, 16'h1234);
    chk("tlabel_noload_ir",  ir_out,  16'hF755);

    mid_reset(1'b1);

    drive(1'b1, 1'b0, 1'b0, 16'hAAAA);
    chk("resume_ir_out", ir_out, 16'hAAAA);

    drive(1'b0, 1'b1, 1'b1, 16'hABCD);
`ifdef DATAPATH_LABEL_EN
    chk("tl_mar_label", mar_out, 16'h02AA);
`else
    chk("tl_mar_bus",   mar_out, 16'hABCD);
`endif

    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        mid_reset(1'b0);
      end else begin
        drive(1'($urandom), 1'($urandom), 1'($urandom), 16'($urandom));
      end
    end

    cmp_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_datapath
